// File: rtl/ahblite_strobe_ctrl_if.sv
// AHB-Lite slave port plus backend strobe port for ahblite_strobe_ctrl.
// slave modport faces the controller, master modport faces the bus/backend driver.
interface ahblite_strobe_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  HSEL;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic                  bk_ready_i;
    logic [ADDR_WIDTH-1:0] bk_addr_o;
    logic [NB-1:0]         bk_strb_o;
    logic                  bk_wr_o;
    logic                  bk_rd_o;

    modport slave (
        input  HSEL, HTRANS, HWRITE, HSIZE, HADDR, HREADY, bk_ready_i,
        output HREADYOUT, HRESP, bk_addr_o, bk_strb_o, bk_wr_o, bk_rd_o
    );

    modport master (
        output HSEL, HTRANS, HWRITE, HSIZE, HADDR, HREADY, bk_ready_i,
        input  HREADYOUT, HRESP, bk_addr_o, bk_strb_o, bk_wr_o, bk_rd_o
    );
endinterface

// File: rtl/ahblite_strobe_ctrl.sv
// AHB-Lite slave front-end: registers the address phase and drives per-lane byte strobes.
// Define AHBLITE_STRB_ERRCHK_EN to enable illegal-transfer detection with a two-cycle ERROR.

module ahblite_strobe_lane #(
    parameter int LANE = 0,
    parameter int LBW  = 1
) (
    input  logic [LBW-1:0] i_off,
    input  logic [2:0]     i_size,
    output logic           o_en
);
    localparam logic [LBW-1:0] IDX = LBW'(LANE);

    // Lane is inside the size-aligned window when it matches the offset above the size bits.
    assign o_en = ((IDX ^ i_off) >> i_size) == '0;
endmodule

module ahblite_strobe_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahblite_strobe_ctrl_if.slave  bus
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int LB  = $clog2(NB);
    localparam int LBW = (LB > 0) ? LB : 1;

`ifdef AHBLITE_STRB_ERRCHK_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1
    } state_t;
`endif

    state_t                r_state;
    state_t                w_next;
    logic                  w_sample;
    logic                  w_open;
    logic                  w_illegal;
    logic                  w_hreadyout;
    logic                  w_hresp;
    logic [LBW-1:0]        w_off;
    logic [NB-1:0]         w_strb;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NB-1:0]         r_strb;
    logic                  r_wr;
    logic                  r_rd;

    assign w_sample = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

    generate
        if (LB > 0) begin : g_off
            assign w_off = bus.HADDR[LBW-1:0];
        end else begin : g_off0
            assign w_off = '0;
        end
    endgenerate

    generate
        for (genvar g = 0; g < NB; g++) begin : g_lane
            ahblite_strobe_lane #(
                .LANE (g),
                .LBW  (LBW)
            ) u_lane (
                .i_off  (w_off),
                .i_size (bus.HSIZE),
                .o_en   (w_strb[g])
            );
        end
    endgenerate

`ifdef AHBLITE_STRB_ERRCHK_EN
    localparam logic [2:0] LB3 = 3'(LB);
    logic w_oversize;
    logic w_misalign;

    assign w_oversize = bus.HSIZE > LB3;
    // Only meaningful when not oversize, so the size mask fits in the lane-offset bits.
    assign w_misalign = |(w_off & ~({LBW{1'b1}} << bus.HSIZE));
    assign w_illegal  = w_oversize | w_misalign;
`else
    assign w_illegal  = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // w_open marks cycles where a new address phase may be taken (the IDLE rules).
    always_comb begin
        w_next = r_state;
        w_open = 1'b0;
        case (r_state)
            ST_DATA: w_open = bus.bk_ready_i;
`ifdef AHBLITE_STRB_ERRCHK_EN
            ST_ERR1: w_next = ST_ERR2;
            ST_ERR2: w_open = 1'b1;
`endif
            default: w_open = 1'b1;
        endcase
        if (w_open) begin
`ifdef AHBLITE_STRB_ERRCHK_EN
            w_next = !w_sample ? ST_IDLE : (w_illegal ? ST_ERR1 : ST_DATA);
`else
            w_next = w_sample ? ST_DATA : ST_IDLE;
`endif
        end
    end

    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = 1'b0;
        case (r_state)
            ST_DATA: w_hreadyout = bus.bk_ready_i;
`ifdef AHBLITE_STRB_ERRCHK_EN
            ST_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 1'b1;
            end
            ST_ERR2: w_hresp = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_addr <= '0;
            r_strb <= '0;
            r_wr   <= 1'b0;
            r_rd   <= 1'b0;
        end else if (w_open) begin
            if (w_sample && !w_illegal) begin
                r_addr <= bus.HADDR;
                r_strb <= w_strb;
                r_wr   <= bus.HWRITE;
                r_rd   <= !bus.HWRITE;
            end else begin
                r_strb <= '0;
                r_wr   <= 1'b0;
                r_rd   <= 1'b0;
            end
        end
    end

    assign bus.HREADYOUT = w_hreadyout;
    assign bus.HRESP     = w_hresp;
    assign bus.bk_addr_o = r_addr;
    assign bus.bk_strb_o = r_strb;
    assign bus.bk_wr_o   = r_wr;
    assign bus.bk_rd_o   = r_rd;
endmodule

// File: doc/ahblite_strobe_ctrl.md
# ahblite_strobe_ctrl

Parametrised AHB-Lite slave front-end that registers the address phase and generates per-byte lane strobes for any bus width from 8 to 1024 bits. It drives HREADYOUT/HRESP, inserting backend wait states and producing the two-cycle ERROR response for illegal transfers. It sits between the AHB-Lite slave port and a peripheral's register or memory backend, and replaces fixed one-hot size decoding with lane-accurate write/read strobes.

## Interface
- DATA_WIDTH, 32: bus width in bits; one of 8, 16, 32, 64, 128, 256, 512, 1024; NB = DATA_WIDTH/8 lanes, LB = log2(NB).
- ADDR_WIDTH, 32: HADDR width; must be ≥ LB+1.
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select.
- HTRANS  in  2  transfer type; an access is requested when HTRANS[1]=1 (NONSEQ/SEQ).
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size; bytes = 2^HSIZE.
- HADDR  in  ADDR_WIDTH  byte address.
- HREADY  in  1  bus-level ready (HREADYIN).
- bk_ready_i  in  1  backend completes the current data phase this cycle.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- bk_addr_o  out  ADDR_WIDTH  registered HADDR.
- bk_strb_o  out  NB  registered byte-lane strobes; bit i = byte lane i, little-endian.
- bk_wr_o  out  1  write data phase active.
- bk_rd_o  out  1  read data phase active.

## Operation
- Sample condition S = HSEL & HTRANS[1] & HREADY at the rising edge of HCLK.
- Illegal transfer: HSIZE > LB (oversize), or HADDR[HSIZE-1:0] ≠ 0 when HSIZE > 0 (misaligned).
- Strobe: bk_strb_o = ((1 << 2^HSIZE) − 1) << (HADDR[LB-1:0] & ~(2^HSIZE − 1)), truncated to NB bits; computed at full width, with no overflow into bits ≥ NB.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE/DATA with S and legal transfer: go to DATA, latch addr/strb, assert bk_wr_o or bk_rd_o per HWRITE.
  - IDLE/DATA with S and illegal transfer: go to ERR1; strb/wr/rd = 0 (backend is never touched).
  - DATA, bk_ready_i = 0: remain in DATA and hold all backend outputs; HREADY is low, so S cannot occur.
  - DATA, bk_ready_i = 1, no S: go to IDLE and clear wr/rd/strb.
  - ERR1: go to ERR2 unconditionally. ERR2: apply the IDLE rules (a new address phase may be sampled).
- HTRANS IDLE/BUSY or HSEL = 0 gives a zero-wait OKAY.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, bk_addr_o=0, bk_strb_o=0, bk_wr_o=0, bk_rd_o=0.
- Reset asserted mid-transfer: all outputs take reset values at the next edge and the pending access is abandoned without completion.

## Timing
- Backend outputs are registered and valid during the data phase, the cycle after the address phase is sampled.
- Data phase length = 1 + number of cycles with bk_ready_i low.
- HREADYOUT in DATA = bk_ready_i (combinational from the state register and bk_ready_i only); 1 in IDLE and ERR2; 0 in ERR1.
- HRESP = 1 in ERR1 and ERR2, else 0.
- Back-to-back pipelined transfers run at one per cycle when bk_ready_i = 1.
- ERROR response is always exactly 2 cycles.

## Configuration
- AHBLITE_STRB_ERRCHK_EN defined: illegal-transfer detection, ERR1 and ERR2 present as above.
- AHBLITE_STRB_ERRCHK_EN undefined: ERR states removed and HRESP tied to 0. Oversize transfers strobe all NB lanes. Misaligned transfers use the size-aligned lane base from the strobe formula, and the address is passed through unchanged.

## Test plan
- Reset: hold HRESETn=0 for 2 edges mid-DATA -> all outputs at reset values, state IDLE, HREADYOUT=1.
- DATA_WIDTH=32, write, HSIZE=0, HADDR=0x3 -> next cycle bk_strb_o=4'b1000, bk_wr_o=1; HSIZE=1, HADDR=0x2 -> 4'b1100; HSIZE=2, HADDR=0x0 -> 4'b1111.
- DATA_WIDTH=128, read, HSIZE=3, HADDR=0x18 -> bk_strb_o=16'hFF00, bk_rd_o=1.
- bk_ready_i low for 3 cycles -> HREADYOUT=0 for exactly 3 cycles, backend outputs stable, completion on the 4th cycle.
- Macro defined, DATA_WIDTH=32: HSIZE=3 (oversize) or HSIZE=2 with HADDR=0x2 (misaligned) -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, with bk_wr_o/bk_rd_o never asserted.
- Pipelined writes to 0x0, 0x4, 0x8 with bk_ready_i=1 -> three consecutive data-phase cycles with bk_addr_o 0x0, 0x4, 0x8, and HREADYOUT constantly 1.
